// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state encoding and slot geometry defaults for the I2S DAC serializer
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } aud_state_t;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_SLOT_W   = 16;
    localparam int FRAME_BITS   = 2 * DEF_SLOT_W;

endpackage

// File: rtl/aud_bclk_div.sv
// rtl/aud_bclk_div.sv - prescaler and registered BCLK toggle with single-clk edge events
module aud_bclk_div #(
    parameter int HALF_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run_en,
    output logic bclk,
    output logic rise_evt,
    output logic fall_evt
);

    localparam int PW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [PW-1:0] presc;
    logic          tc;

    assign tc       = run_en && (presc == PW'(HALF_DIV - 1));
    // Events coincide with the clk edge on which bclk toggles.
    assign rise_evt = tc && !bclk;
    assign fall_evt = tc && bclk;

    always_ff @(posedge clk) begin
        if (reset || !run_en) begin
            presc <= '0;
            bclk  <= 1'b0;
        end else if (tc) begin
            presc <= '0;
            bclk  <= !bclk;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - one-sample holding register and mono I2S serializer; DAC_UNDERRUN_CNT_EN adds underrun_count
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W      = DEF_SAMPLE_W,
    parameter int SLOT_W        = DEF_SLOT_W,
    parameter int BCLK_HALF_DIV = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_dacdat,
    output logic                frame_start,
    output logic                underrun,
    output logic                busy
`ifdef DAC_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_count
`endif
);

    localparam int FRAME_LEN = 2 * SLOT_W;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    aud_state_t          state, state_d;
    logic                hold_full;
    logic [SAMPLE_W-1:0] hold_data;
    logic [SAMPLE_W-1:0] frame_sample;
    logic [SLOT_W-1:0]   shreg;
    logic [SLOT_W-1:0]   shreg_load;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_nxt;
    logic                run_en;
    logic                fall_evt;
    logic                unused_rise_evt;
    logic                accept;
    logic                entry;
    logic                frame_edge;
    logic                consume;
    logic                underrun_evt;
    logic                go_idle;
    logic                slot_first;

    assign run_en = (state != IDLE);

    aud_bclk_div #(
        .HALF_DIV (BCLK_HALF_DIV)
    ) u_bclk_div (
        .clk      (clk),
        .reset    (reset),
        .run_en   (run_en),
        .bclk     (aud_bclk),
        .rise_evt (unused_rise_evt),
        .fall_evt (fall_evt)
    );

    assign bit_cnt_nxt  = (bit_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : bit_cnt + 1'b1;
    assign slot_first   = (bit_cnt_nxt == CNT_W'(1)) || (bit_cnt_nxt == CNT_W'(SLOT_W + 1));
    // Left-justify the sample inside the slot; unused low slot bits carry zeros.
    assign shreg_load   = SLOT_W'(frame_sample) << (SLOT_W - SAMPLE_W);

    assign sample_ready = !hold_full;
    assign accept       = sample_valid && !hold_full;
    assign entry        = (state == IDLE) && (state_d == RUN);
    assign frame_edge   = (state == RUN) && fall_evt && (bit_cnt_nxt == '0);
    assign consume      = entry || (frame_edge && hold_full);
    assign underrun_evt = frame_edge && !hold_full;
    assign go_idle      = (state == DRAIN) && fall_evt && (bit_cnt_nxt == CNT_W'(1));
    assign aud_dacdat   = shreg[SLOT_W-1];
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (enable && hold_full) state_d = RUN;
            RUN:     if (!enable)             state_d = DRAIN;
            DRAIN:   if (go_idle)             state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Holding register: a consume and an accept can never coincide, since one needs full and the other empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (consume) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_sample <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            aud_daclrck  <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (entry) begin
                frame_sample <= hold_data;
                frame_start  <= 1'b1;
                shreg        <= '0;
                bit_cnt      <= '0;
                aud_daclrck  <= 1'b0;
            end else if (state == IDLE || go_idle) begin
                shreg       <= '0;
                bit_cnt     <= '0;
                aud_daclrck <= 1'b0;
            end else if (fall_evt) begin
                bit_cnt     <= bit_cnt_nxt;
                aud_daclrck <= (bit_cnt_nxt >= CNT_W'(SLOT_W));
                shreg       <= slot_first ? shreg_load : {shreg[SLOT_W-2:0], 1'b0};
                // On underrun the previous frame_sample is simply replayed.
                if (frame_edge && hold_full) begin
                    frame_sample <= hold_data;
                    frame_start  <= 1'b1;
                end
                if (underrun_evt) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

`ifdef DAC_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (underrun_evt && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule
